uart_fifo_core: RTL and testbench



---
 rtl/uart_pkg.sv | 38 +++
 rtl/uart_sync_fifo.sv | 74 +++++++
 rtl/uart_fifo_core.sv | 319 +++++++++++++++++++++++++++++++
 tb/tb_uart_fifo_core.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared register offsets, STATUS bit positions, engine state
//               encoding and bit-timing helper for the UART FIFO core.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Register offsets relative to the device start address
    localparam logic [31:0] c_reg_data   = 32'd0;
    localparam logic [31:0] c_reg_status = 32'd1;
    localparam logic [31:0] c_reg_ctrl   = 32'd2;

    // STATUS register bit positions
    localparam int c_st_rx_empty   = 0;
    localparam int c_st_rx_full    = 1;
    localparam int c_st_tx_empty   = 2;
    localparam int c_st_tx_full    = 3;
    localparam int c_st_tx_busy    = 4;
    localparam int c_st_rx_overrun = 5;
    localparam int c_st_rx_break   = 6;

    // Frame phases shared by the transmit and receive engines
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // Number of system clocks spanned by one serial bit
    function automatic int calc_cycles_per_bit(input int clock_freq, input int bit_rate);
        return clock_freq / bit_rate;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync_fifo
// Description : Single-clock first-word-fall-through FIFO. The head entry is
//               visible on o_rd_data whenever the FIFO is not empty.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr_q;
    logic [c_ptr_w-1:0] w_wr_ptr_d;
    logic [c_ptr_w-1:0] r_rd_ptr_q;
    logic [c_ptr_w-1:0] w_rd_ptr_d;
    logic [c_cnt_w-1:0] r_count_q;
    logic [c_cnt_w-1:0] w_count_d;
    logic               w_do_wr;
    logic               w_do_rd;

    assign o_empty   = (r_count_q == '0);
    assign o_full    = (r_count_q == c_cnt_w'(DEPTH));
    assign o_rd_data = r_mem[r_rd_ptr_q];

    // Qualify requests; a write into a full FIFO is allowed when a read frees a slot
    always_comb begin
        w_do_rd    = i_rd_en && !o_empty;
        w_do_wr    = i_wr_en && (!o_full || w_do_rd);
        w_wr_ptr_d = w_do_wr ? r_wr_ptr_q + c_ptr_w'(1) : r_wr_ptr_q;
        w_rd_ptr_d = w_do_rd ? r_rd_ptr_q + c_ptr_w'(1) : r_rd_ptr_q;
        w_count_d  = r_count_q;
        if (w_do_wr && !w_do_rd) begin
            w_count_d = r_count_q + c_cnt_w'(1);
        end else if (!w_do_wr && w_do_rd) begin
            w_count_d = r_count_q - c_cnt_w'(1);
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
        end
    end

    // Storage array; contents are meaningless while the count is zero
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr_q] <= i_wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_fifo_core.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo_core
// Description : Memory-mapped 8N1 UART with FIFO-buffered transmitter and
//               receiver, DATA / STATUS / CTRL registers on a simple bus.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo_core
    import uart_pkg::*;
#(
    parameter int          CLOCK_FREQ           = 25000000,
    parameter int          BIT_RATE             = 9600,
    parameter int          PAYLOAD_BITS         = 8,
    parameter logic [31:0] DEVICE_START_ADDRESS = 32'h0000_1003,
    parameter logic [31:0] DEVICE_FINAL_ADDRESS = 32'h0000_1005,
    parameter int          BUFFER_SIZE          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        tx,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data
);

    localparam int c_cpb   = calc_cycles_per_bit(CLOCK_FREQ, BIT_RATE);
    localparam int c_cnt_w = $clog2(c_cpb);
    localparam int c_bit_w = $clog2(PAYLOAD_BITS);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_cpb - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_half = c_cnt_w'(c_cpb / 2 - 1);
    localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(PAYLOAD_BITS - 1);

    // ---------------- bus decode ----------------
    logic        w_in_range;
    logic [31:0] w_offset;
    logic        w_sel_data;
    logic        w_sel_status;
    logic        w_sel_ctrl;
    logic        w_tx_push;
    logic        w_rx_pop;
    logic        w_ctrl_clear;
    logic        w_unused_wdata;

    assign w_in_range   = (address >= DEVICE_START_ADDRESS) && (address <= DEVICE_FINAL_ADDRESS);
    assign w_offset     = address - DEVICE_START_ADDRESS;
    assign w_sel_data   = w_in_range && (w_offset == c_reg_data);
    assign w_sel_status = w_in_range && (w_offset == c_reg_status);
    assign w_sel_ctrl   = w_in_range && (w_offset == c_reg_ctrl);
    assign w_tx_push    = write && w_sel_data;
    assign w_rx_pop     = read && w_sel_data;
    assign w_ctrl_clear = write && w_sel_ctrl && write_data[0];
    assign w_unused_wdata = &{1'b0, write_data[31:PAYLOAD_BITS]};

    // ---------------- FIFOs ----------------
    logic [PAYLOAD_BITS-1:0] w_tx_head;
    logic                    w_tx_empty;
    logic                    w_tx_full;
    logic                    w_tx_pop;
    logic [PAYLOAD_BITS-1:0] w_rx_head;
    logic                    w_rx_empty;
    logic                    w_rx_full;
    logic                    w_rx_push;
    logic [PAYLOAD_BITS-1:0] r_rx_shift_q;

    uart_sync_fifo #(.DEPTH(BUFFER_SIZE), .WIDTH(PAYLOAD_BITS)) u_tx_fifo (
        .clk       (clk),
        .rst       (reset),
        .i_wr_en   (w_tx_push),
        .i_wr_data (write_data[PAYLOAD_BITS-1:0]),
        .i_rd_en   (w_tx_pop),
        .o_rd_data (w_tx_head),
        .o_empty   (w_tx_empty),
        .o_full    (w_tx_full)
    );

    uart_sync_fifo #(.DEPTH(BUFFER_SIZE), .WIDTH(PAYLOAD_BITS)) u_rx_fifo (
        .clk       (clk),
        .rst       (reset),
        .i_wr_en   (w_rx_push),
        .i_wr_data (r_rx_shift_q),
        .i_rd_en   (w_rx_pop),
        .o_rd_data (w_rx_head),
        .o_empty   (w_rx_empty),
        .o_full    (w_rx_full)
    );

    // ---------------- transmitter ----------------
    uart_state_e             r_tx_state_q, w_tx_state_d;
    logic [c_cnt_w-1:0]      r_tx_cnt_q,   w_tx_cnt_d;
    logic [c_bit_w-1:0]      r_tx_bit_q,   w_tx_bit_d;
    logic [PAYLOAD_BITS-1:0] r_tx_shift_q, w_tx_shift_d;
    logic                    r_tx_line_q,  w_tx_line_d;

    assign tx = r_tx_line_q;

    // TX next-state: the line register is updated on the same edge as the
    // state so each bit level lasts exactly one bit time; STOP chains
    // straight into START when another byte is waiting
    always_comb begin
        w_tx_state_d = r_tx_state_q;
        w_tx_cnt_d   = r_tx_cnt_q + c_cnt_w'(1);
        w_tx_bit_d   = r_tx_bit_q;
        w_tx_shift_d = r_tx_shift_q;
        w_tx_line_d  = r_tx_line_q;
        w_tx_pop     = 1'b0;
        case (r_tx_state_q)
            ST_IDLE: begin
                w_tx_cnt_d  = '0;
                w_tx_line_d = 1'b1;
                if (!w_tx_empty) begin
                    w_tx_pop     = 1'b1;
                    w_tx_shift_d = w_tx_head;
                    w_tx_line_d  = 1'b0;
                    w_tx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (r_tx_cnt_q == c_cnt_last) begin
                    w_tx_cnt_d   = '0;
                    w_tx_bit_d   = '0;
                    w_tx_line_d  = r_tx_shift_q[0];
                    w_tx_state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_tx_cnt_q == c_cnt_last) begin
                    w_tx_cnt_d = '0;
                    if (r_tx_bit_q == c_bit_last) begin
                        w_tx_line_d  = 1'b1;
                        w_tx_state_d = ST_STOP;
                    end else begin
                        w_tx_bit_d   = r_tx_bit_q + c_bit_w'(1);
                        w_tx_shift_d = r_tx_shift_q >> 1;
                        w_tx_line_d  = r_tx_shift_q[1];
                    end
                end
            end
            ST_STOP: begin
                if (r_tx_cnt_q == c_cnt_last) begin
                    w_tx_cnt_d = '0;
                    if (!w_tx_empty) begin
                        w_tx_pop     = 1'b1;
                        w_tx_shift_d = w_tx_head;
                        w_tx_line_d  = 1'b0;
                        w_tx_state_d = ST_START;
                    end else begin
                        w_tx_state_d = ST_IDLE;
                    end
                end
            end
            default: w_tx_state_d = ST_IDLE;
        endcase
    end

    // TX registers; reset forces the line high at once and abandons any frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_state_q <= ST_IDLE;
            r_tx_cnt_q   <= '0;
            r_tx_bit_q   <= '0;
            r_tx_shift_q <= '0;
            r_tx_line_q  <= 1'b1;
        end else begin
            r_tx_state_q <= w_tx_state_d;
            r_tx_cnt_q   <= w_tx_cnt_d;
            r_tx_bit_q   <= w_tx_bit_d;
            r_tx_shift_q <= w_tx_shift_d;
            r_tx_line_q  <= w_tx_line_d;
        end
    end

    // ---------------- receiver ----------------
    logic                    r_rx_meta_q;
    logic                    r_rx_sync_q;
    uart_state_e             r_rx_state_q, w_rx_state_d;
    logic [c_cnt_w-1:0]      r_rx_cnt_q,   w_rx_cnt_d;
    logic [c_bit_w-1:0]      r_rx_bit_q,   w_rx_bit_d;
    logic [PAYLOAD_BITS-1:0] w_rx_shift_d;
    logic                    r_rx_armed_q, w_rx_armed_d;
    logic                    r_overrun_q,  w_overrun_d;
    logic                    r_break_q,    w_break_d;
    logic                    w_set_overrun;
    logic                    w_set_break;

    // Two-flop synchronizer for the asynchronous serial input (idles high)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta_q <= 1'b1;
            r_rx_sync_q <= 1'b1;
        end else begin
            r_rx_meta_q <= rx;
            r_rx_sync_q <= r_rx_meta_q;
        end
    end

    // RX next-state: start bit is confirmed at half a bit, data is sampled at
    // bit centres, and after each frame the engine waits for an idle line
    // before it will accept another start bit
    always_comb begin
        w_rx_state_d  = r_rx_state_q;
        w_rx_cnt_d    = r_rx_cnt_q + c_cnt_w'(1);
        w_rx_bit_d    = r_rx_bit_q;
        w_rx_shift_d  = r_rx_shift_q;
        w_rx_armed_d  = r_rx_armed_q;
        w_rx_push     = 1'b0;
        w_set_overrun = 1'b0;
        w_set_break   = 1'b0;
        case (r_rx_state_q)
            ST_IDLE: begin
                w_rx_cnt_d = '0;
                if (!r_rx_armed_q) begin
                    w_rx_armed_d = r_rx_sync_q;
                end else if (!r_rx_sync_q) begin
                    w_rx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (r_rx_cnt_q == c_cnt_half) begin
                    w_rx_cnt_d = '0;
                    w_rx_bit_d = '0;
                    w_rx_state_d = r_rx_sync_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_rx_cnt_q == c_cnt_last) begin
                    w_rx_cnt_d   = '0;
                    w_rx_shift_d = {r_rx_sync_q, r_rx_shift_q[PAYLOAD_BITS-1:1]};
                    if (r_rx_bit_q == c_bit_last) begin
                        w_rx_state_d = ST_STOP;
                    end else begin
                        w_rx_bit_d = r_rx_bit_q + c_bit_w'(1);
                    end
                end
            end
            ST_STOP: begin
                if (r_rx_cnt_q == c_cnt_last) begin
                    w_rx_cnt_d   = '0;
                    w_rx_armed_d = 1'b0;
                    w_rx_state_d = ST_IDLE;
                    if (r_rx_sync_q) begin
                        if (w_rx_full && !w_rx_pop) begin
                            w_set_overrun = 1'b1;
                        end else begin
                            w_rx_push = 1'b1;
                        end
                    end else if (r_rx_shift_q == '0) begin
                        w_set_break = 1'b1;
                    end
                end
            end
            default: w_rx_state_d = ST_IDLE;
        endcase
    end

    // Sticky error flags; a set in the same cycle as a CTRL clear takes priority
    always_comb begin
        w_overrun_d = r_overrun_q;
        w_break_d   = r_break_q;
        if (w_ctrl_clear) begin
            w_overrun_d = 1'b0;
            w_break_d   = 1'b0;
        end
        if (w_set_overrun) begin
            w_overrun_d = 1'b1;
        end
        if (w_set_break) begin
            w_break_d = 1'b1;
        end
    end

    // RX registers and sticky flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_state_q <= ST_IDLE;
            r_rx_cnt_q   <= '0;
            r_rx_bit_q   <= '0;
            r_rx_shift_q <= '0;
            r_rx_armed_q <= 1'b0;
            r_overrun_q  <= 1'b0;
            r_break_q    <= 1'b0;
        end else begin
            r_rx_state_q <= w_rx_state_d;
            r_rx_cnt_q   <= w_rx_cnt_d;
            r_rx_bit_q   <= w_rx_bit_d;
            r_rx_shift_q <= w_rx_shift_d;
            r_rx_armed_q <= w_rx_armed_d;
            r_overrun_q  <= w_overrun_d;
            r_break_q    <= w_break_d;
        end
    end

    // ---------------- read path ----------------
    logic [31:0] w_status;

    // Read mux; unmapped or idle bus returns zero, empty RX FIFO reads as zero
    always_comb begin
        w_status                  = '0;
        w_status[c_st_rx_empty]   = w_rx_empty;
        w_status[c_st_rx_full]    = w_rx_full;
        w_status[c_st_tx_empty]   = w_tx_empty;
        w_status[c_st_tx_full]    = w_tx_full;
        w_status[c_st_tx_busy]    = (r_tx_state_q != ST_IDLE);
        w_status[c_st_rx_overrun] = r_overrun_q;
        w_status[c_st_rx_break]   = r_break_q;
        read_data = '0;
        if (read) begin
            if (w_sel_data && !w_rx_empty) begin
                read_data[PAYLOAD_BITS-1:0] = w_rx_head;
            end else if (w_sel_status) begin
                read_data = w_status;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_fifo_core
// Description : Directed self-checking bench for uart_fifo_core with TX/RX
//               byte scoreboards (10 clocks per bit).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_fifo_core;

    localparam logic [31:0] c_a_data   = 32'h0000_1003;
    localparam logic [31:0] c_a_status = 32'h0000_1004;
    localparam logic [31:0] c_a_ctrl   = 32'h0000_1005;
    localparam int          c_cpb      = 10;
    localparam int          c_depth    = 8;

    logic        clk;
    logic        reset;
    logic        rx;
    logic        tx;
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;

    int          total = 0;
    int          bad   = 0;
    int          tx_frames = 0;
    int          rx_cnt = 0;
    bit          mon_en = 1'b0;
    logic [7:0]  tx_q [$];
    logic [7:0]  rx_q [$];

    uart_fifo_core #(
        .CLOCK_FREQ           (1000000),
        .BIT_RATE             (100000),
        .PAYLOAD_BITS         (8),
        .DEVICE_START_ADDRESS (32'h0000_1003),
        .DEVICE_FINAL_ADDRESS (32'h0000_1005),
        .BUFFER_SIZE          (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .tx         (tx),
        .read       (read),
        .write      (write),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        write_data = d;
        write      = 1'b1;
        @(negedge clk);
        write      = 1'b0;
    endtask

    task automatic bus_read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        @(negedge clk);
        address = a;
        read    = 1'b1;
        #1;
        check(tag, read_data, exp);
        @(negedge clk);
        read    = 1'b0;
    endtask

    // Pop the RX scoreboard (zero if nothing is expected) and read DATA
    task automatic read_rx(input string tag);
        logic [7:0] e;
        e = 8'h00;
        if (rx_q.size() != 0) begin
            e = rx_q.pop_front();
            rx_cnt--;
        end
        bus_read_check(tag, c_a_data, {24'h0, e});
    endtask

    // Drive one 8N1 frame; the byte is expected back only if the FIFO has room
    task automatic send_rx(input logic [7:0] b);
        if (rx_cnt < c_depth) begin
            rx_q.push_back(b);
            rx_cnt++;
        end
        @(negedge clk);
        rx = 1'b0;
        repeat (c_cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (c_cpb) @(negedge clk);
        end
        rx = 1'b1;
        repeat (c_cpb + 2) @(negedge clk);
    endtask

    // Serial monitor: decode each TX frame at bit centres and score it
    initial begin
        forever begin
            @(negedge tx);
            if (mon_en) begin
                logic [7:0] b;
                b = 8'h00;
                repeat (c_cpb / 2) @(negedge clk);
                check("tx_start_bit", {31'h0, tx}, 32'h0);
                for (int i = 0; i < 8; i++) begin
                    repeat (c_cpb) @(negedge clk);
                    b[i] = tx;
                end
                repeat (c_cpb) @(negedge clk);
                check("tx_stop_bit", {31'h0, tx}, 32'h1);
                tx_frames++;
                check("tx_frame_expected", {31'h0, tx_q.size() != 0}, 32'h1);
                if (tx_q.size() != 0) begin
                    check("tx_byte", {24'h0, b}, {24'h0, tx_q.pop_front()});
                end
            end
        end
    end

    initial begin
        int f0;
        rx = 1'b1; read = 1'b0; write = 1'b0; address = '0; write_data = '0;
        reset = 1'b1;

        // ---- reset ----
        repeat (3) @(negedge clk);
        check("reset_tx", {31'h0, tx}, 32'h1);
        check("reset_rdata", read_data, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        bus_read_check("reset_status", c_a_status, 32'h05);
        bus_read_check("unmapped_hi", 32'h0000_1006, 32'h0);
        bus_read_check("unmapped_lo", 32'h0000_1002, 32'h0);
        bus_read_check("ctrl_reads_zero", c_a_ctrl, 32'h0);
        bus_read_check("data_empty_zero", c_a_data, 32'h0);
        mon_en = 1'b1;

        // ---- single TX frame 0xA5 (upper write bits ignored) ----
        tx_q.push_back(8'hA5);
        @(negedge clk);
        address = c_a_data; write_data = 32'hFFFF_FFA5; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
        check("tx_idle_at_write_edge", {31'h0, tx}, 32'h1);
        @(negedge clk);
        check("tx_low_next_cycle", {31'h0, tx}, 32'h0);
        repeat (40) @(negedge clk);
        bus_read_check("status_tx_busy", c_a_status, 32'h15);
        repeat (70) @(negedge clk);
        bus_read_check("status_after_tx", c_a_status, 32'h05);
        check("tx_one_frame", tx_frames, 32'd1);

        // ---- TX FIFO overflow: engine takes 0x00, FIFO fills with 0x01..0x08, 0x09 dropped ----
        f0 = tx_frames;
        for (int i = 0; i < 9; i++) tx_q.push_back(8'(i));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            address = c_a_data; write_data = i; write = 1'b1;
        end
        @(negedge clk);
        write = 1'b0;
        bus_read_check("status_tx_full", c_a_status, 32'h19);
        repeat (9 * 10 * c_cpb + 20) @(negedge clk);
        check("tx_nine_frames", tx_frames - f0, 32'd9);
        check("tx_scoreboard_drained", tx_q.size(), 32'd0);
        bus_read_check("status_after_burst", c_a_status, 32'h05);

        // ---- RX single byte ----
        send_rx(8'h3C);
        bus_read_check("status_rx_avail", c_a_status, 32'h04);
        read_rx("rx_data_3c");
        bus_read_check("status_rx_drained", c_a_status, 32'h05);

        // ---- RX overrun: 9 frames into an 8-deep FIFO ----
        for (int i = 0; i < 9; i++) send_rx(8'(i * 37 + 5));
        bus_read_check("status_overrun", c_a_status, 32'h26);
        for (int i = 0; i < 8; i++) read_rx("rx_data_in_order");
        bus_read_check("status_overrun_sticky", c_a_status, 32'h25);

        // ---- break: line low for 12 bit times ----
        @(negedge clk);
        rx = 1'b0;
        repeat (12 * c_cpb) @(negedge clk);
        rx = 1'b1;
        repeat (2 * c_cpb) @(negedge clk);
        bus_read_check("status_break", c_a_status, 32'h65);
        bus_write(c_a_ctrl, 32'h1);
        bus_read_check("status_flags_cleared", c_a_status, 32'h05);

        // ---- glitch is rejected, receiver still works afterwards ----
        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (3 * c_cpb) @(negedge clk);
        bus_read_check("status_after_glitch", c_a_status, 32'h05);
        send_rx(8'h5A);
        read_rx("rx_data_after_glitch");
        bus_read_check("status_end_rx", c_a_status, 32'h05);

        // ---- reset during a TX data bit ----
        mon_en = 1'b0;
        bus_write(c_a_data, 32'h00);
        bus_write(c_a_data, 32'h55);
        repeat (30) @(negedge clk);
        check("tx_low_in_data_bit", {31'h0, tx}, 32'h0);
        reset = 1'b1;
        #1;
        check("tx_high_on_reset", {31'h0, tx}, 32'h1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bus_read_check("status_after_midreset", c_a_status, 32'h05);
        repeat (15 * c_cpb) @(negedge clk);
        check("tx_idle_after_reset", {31'h0, tx}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
